// File: rtl/div_seq.sv
// Multi-cycle divider for the EX stage: DIV/DIVU as a radix-2 restoring
// shift-subtract, one quotient bit per clock. Holds the pipeline through
// stallreq_o and returns {remainder, quotient} for the HI/LO write.
module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ST_FREE    = 2'b00,
      ST_BY_ZERO = 2'b01,
      ST_ON      = 2'b10,
      ST_END     = 2'b11
   } state_t;

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic [DATA_W-1:0]         abs_b;
   logic [2*DATA_W-1:0]       work;      // {partial remainder, quotient}
   logic                      neg_quo;
   logic                      neg_rem;

   logic signed [DATA_W-1:0]  op_a;
   logic signed [DATA_W-1:0]  op_b;
   logic [DATA_W:0]           sh_rem;
   logic                      sub_ok;
   logic [DATA_W-1:0]         sub_rem;
   logic [DATA_W-1:0]         step_rem;
   logic [DATA_W-1:0]         step_quo;

   // Magnitude of an operand; the most negative value maps to 2^(W-1) unsigned.
   function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                             input logic use_sign);
      if (use_sign && (x < 0))
         mag = $unsigned(-x);
      else
         mag = $unsigned(x);
   endfunction

   // Two's-complement negate when en is set (wraps for the most negative value).
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                  input logic en);
      if (en)
         cond_neg = (~x) + DATA_W'(1);
      else
         cond_neg = x;
   endfunction

   assign op_a = opdata1_i;
   assign op_b = opdata2_i;

   assign stallreq_o = start_i & ~ready_o & ~annul_i;

   // One restoring step: shift the work register left, trial-subtract |b|.
   always_comb begin
      sh_rem   = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
      sub_ok   = (sh_rem >= {1'b0, abs_b});
      // The true difference is below |b| when kept, so W bits suffice.
      sub_rem  = sh_rem[DATA_W-1:0] - abs_b;
      step_rem = sub_ok ? sub_rem : sh_rem[DATA_W-1:0];
      step_quo = {work[DATA_W-2:0], sub_ok};
   end

   // Sequencer FSM with registered result/ready; data registers are only
   // loaded, never cleared, since every accept overwrites them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FREE;
         cnt      <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            ST_FREE: begin
               ready_o <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= ST_BY_ZERO;
                  end else begin
                     abs_b   <= mag(op_b, signed_div_i);
                     work    <= {{DATA_W{1'b0}}, mag(op_a, signed_div_i)};
                     neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
                     cnt     <= '0;
                     state   <= ST_ON;
                  end
               end
            end
            ST_BY_ZERO: begin
               if (annul_i) begin
                  state <= ST_FREE;
               end else begin
                  work  <= '0;
                  state <= ST_END;
               end
            end
            ST_ON: begin
               if (annul_i) begin
                  state <= ST_FREE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_W - 1)) begin
                     work  <= {cond_neg(step_rem, neg_rem), cond_neg(step_quo, neg_quo)};
                     state <= ST_END;
                  end else begin
                     work <= {step_rem, step_quo};
                  end
               end
            end
            ST_END: begin
               if (annul_i || !start_i) begin
                  ready_o <= 1'b0;
                  state   <= ST_FREE;
               end else begin
                  ready_o  <= 1'b1;
                  result_o <= work;
               end
            end
            default: begin
               ready_o <= 1'b0;
               state   <= ST_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: expected results are queued when a divide is issued and
// compared when ready_o rises; latency, stall, annul and reset are also checked.
module tb_div_seq;

   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            signed_div_i;
   logic [W-1:0]    opdata1_i;
   logic [W-1:0]    opdata2_i;
   logic            start_i;
   logic            annul_i;
   logic [2*W-1:0]  result_o;
   logic            ready_o;
   logic            stallreq_o;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] exp_q[$];

   div_seq #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Reference built on the simulator's own / and % operators.
   function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [W-1:0] uq, ur;
      if (b == 0) return '0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[W-1:0], q[W-1:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide, wait for ready_o, compare result, latency and stall length.
   task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp,
                          input int exp_lat, input logic mess);
      int n;
      int stall_cnt;
      logic [2*W-1:0] want;
      exp_q.push_back(exp);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();                      // accept edge
      if (mess) begin
         opdata1_i    = $urandom;
         opdata2_i    = '0;
         signed_div_i = ~sgn;
      end
      n = 0;
      stall_cnt = 0;
      while (!ready_o && n < 100) begin
         if (stallreq_o) stall_cnt++;
         tick();
         n++;
      end
      if (!ready_o) begin
         chk({tag, "_timeout"}, 64'(n), 64'(exp_lat));
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
         chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
         chk({tag, "_stall_len"}, 64'(stall_cnt), 64'(exp_lat));
         chk({tag, "_stall_ready"}, 64'(stallreq_o), 64'(0));
         if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'(0), 64'(1));
         end else begin
            want = exp_q.pop_front();
            chk({tag, "_result"}, result_o, want);
         end
      end
      start_i = 1'b0;
      tick();
      chk({tag, "_ready_drop"}, 64'(ready_o), 64'(0));
      chk({tag, "_hold"}, result_o, exp);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      int           hits;

      rst = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      tick();
      tick();
      chk("rst_ready", 64'(ready_o), 64'(0));
      chk("rst_result", result_o, 64'(0));
      chk("rst_stall", 64'(stallreq_o), 64'(0));
      rst = 1'b0;
      tick();

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 1'b0);
      run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33, 1'b0);
      run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 1'b0);
      run_div("div_by_zero", 1'b1, 32'd5, 32'd0, 64'd0, 2, 1'b0);

      // Annul in the middle of a divide.
      signed_div_i = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      tick();
      repeat (10) tick();
      annul_i = 1'b1;
      #1;
      chk("annul_stall", 64'(stallreq_o), 64'(0));
      tick();
      annul_i = 1'b0;
      start_i = 1'b0;
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) hits++;
         tick();
      end
      chk("annul_no_ready", 64'(hits), 64'(0));
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

      // Reset while a divide is in flight.
      signed_div_i = 1'b0;
      opdata1_i = 32'd77;
      opdata2_i = 32'd5;
      start_i = 1'b1;
      tick();
      repeat (20) tick();
      start_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 64'(ready_o), 64'(0));
      chk("midrst_result", result_o, 64'(0));
      chk("midrst_stall", 64'(stallreq_o), 64'(0));
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) hits++;
         tick();
      end
      chk("midrst_no_ready", 64'(hits), 64'(0));

      // Operands disturbed after the accept edge.
      run_div("mess_div", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b1);

      // Random mix, with reference results.
      for (int i = 0; i < 8; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(1, 15));
            1: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            2: rb = (i == 5) ? 32'd0 : $urandom;
            default: rb = $urandom;
         endcase
         run_div("rand", rs, ra, rb, ref_div(rs, ra, rb), (rb == 0) ? 2 : 33, 1'($urandom_range(0, 1)));
      end

      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
